// File: rtl/sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtract controller.
// Contents:
//   SUB_WIDTH_DEFAULT : default operand/result width.
//   state_t           : controller FSM encoding (IDLE, RUN, DONE), 2 bits wide.
package sub_ctrl_pkg;

  localparam int SUB_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bit_sub_cell.sv
// One-bit full subtractor: computes x - y - z for single bits.
// Ports:
//   x  in  minuend bit
//   y  in  subtrahend bit
//   z  in  borrow-in
//   d  out difference bit
//   b  out borrow-out
// Purely combinational.
module bit_sub_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic d,
  output logic b
);

  assign d = x ^ y ^ z;
  assign b = (~x & y) | (~x & z) | (y & z);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtract controller: d = x - y - z computed LSB-first over WIDTH
// cycles through a single bit_sub_cell, with the borrow recirculated in a
// register. Valid/ready handshakes on both the operand and result sides.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clr               synchronous abort back to IDLE (d/b keep last value)
//   in_valid/in_ready operand handshake; in_ready high only in IDLE
//   x, y, z           minuend, subtrahend, borrow-in
//   out_valid/out_ready result handshake; out_valid high only in DONE
//   d, b              difference (mod 2^WIDTH) and borrow-out
//   busy              high while bits are being processed (RUN)
//   v                 two's-complement overflow flag (only with SUB_OVERFLOW_EN)
// Optional feature macro: SUB_OVERFLOW_EN adds output v.
module serial_subtractor_ctrl
  import sub_ctrl_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             b,
`ifdef SUB_OVERFLOW_EN
  output logic             v,
`endif
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] xs_q, xs_d;
  logic [WIDTH-1:0] ys_q, ys_d;
  logic             brw_q, brw_d;
  // Only WIDTH-1 bits are kept: the last difference bit goes straight into d.
  logic [WIDTH-2:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             b_q, b_d;
`ifdef SUB_OVERFLOW_EN
  logic             xm_q, xm_d;
  logic             ym_q, ym_d;
  logic             v_q, v_d;
`endif

  logic             dbit_s;
  logic             bout_s;
  logic [WIDTH-1:0] shift_s;

  bit_sub_cell u_cell (
    .x (xs_q[0]),
    .y (ys_q[0]),
    .z (brw_q),
    .d (dbit_s),
    .b (bout_s)
  );

  // Difference shift register with the new bit entering at the top.
  assign shift_s = {dbit_s, dsr_q};

  // Next-state, counter and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    brw_d   = brw_q;
    dsr_d   = dsr_q;
    d_d     = d_q;
    b_d     = b_q;
`ifdef SUB_OVERFLOW_EN
    xm_d    = xm_q;
    ym_d    = ym_q;
    v_d     = v_q;
`endif
    if (clr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            xs_d    = x;
            ys_d    = y;
            brw_d   = z;
            cnt_d   = '0;
            dsr_d   = '0;
`ifdef SUB_OVERFLOW_EN
            xm_d    = x[WIDTH-1];
            ym_d    = y[WIDTH-1];
`endif
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RUN: begin
          xs_d  = xs_q >> 1;
          ys_d  = ys_q >> 1;
          brw_d = bout_s;
          dsr_d = shift_s[WIDTH-1:1];
          if (cnt_q == CNT_LAST) begin
            d_d     = shift_s;
            b_d     = bout_s;
`ifdef SUB_OVERFLOW_EN
            // dbit_s is the result MSB on this final step.
            v_d     = (xm_q ^ ym_q) & (xm_q ^ dbit_s);
`endif
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      brw_q   <= 1'b0;
      dsr_q   <= '0;
      d_q     <= '0;
      b_q     <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      xm_q    <= 1'b0;
      ym_q    <= 1'b0;
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      brw_q   <= brw_d;
      dsr_q   <= dsr_d;
      d_q     <= d_d;
      b_q     <= b_d;
`ifdef SUB_OVERFLOW_EN
      xm_q    <= xm_d;
      ym_q    <= ym_d;
      v_q     <= v_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN);
  assign d         = d_q;
  assign b         = b_q;
`ifdef SUB_OVERFLOW_EN
  assign v         = v_q;
`endif

endmodule
